// File: rtl/tictactoe_game_ctrl.sv
// Tic-tac-toe game sequencer: accepts moves over valid/ready, owns the X/O boards
// that feed the combinational board checker, and turns its flags into a result.
module tictactoe_game_ctrl #(
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic       move_ready,
  output logic       move_accept,
  output logic       move_reject,
  output logic [8:0] x_board,
  output logic [8:0] o_board,
  input  logic       win_x,
  input  logic       win_o,
  input  logic       full,
  input  logic       error,
  output logic       turn,
  output logic [3:0] move_count,
  output logic       game_over,
  output logic [1:0] result,
  output logic       fault
);

  // state   | meaning
  // S_PLAY  | waiting for a move; move_ready high
  // S_CHECK | one cycle: checker flags reflect the just-updated boards
  // S_DONE  | game finished; boards and result frozen, moves refused
  typedef enum logic [1:0] {S_PLAY, S_CHECK, S_DONE} state_e;

  state_e     state_q;
  logic [8:0] x_q, o_q;
  logic       turn_q;
  logic [3:0] cnt_q;
  logic [1:0] result_q;
  logic       fault_q, accept_q, reject_q;

  logic [8:0] cell_mask_d;
  logic       legal_d;

  // Shifting past bit 8 yields zero, so positions 9..15 never look occupied;
  // the explicit range check is what rejects them.
  assign cell_mask_d = 9'd1 << move_pos;
  assign legal_d     = (move_pos <= 4'd8) && (((x_q | o_q) & cell_mask_d) == 9'd0);

  always_ff @(posedge clk) begin
    accept_q <= 1'b0;
    reject_q <= 1'b0;
    if (!rst_n || new_game) begin
      state_q  <= S_PLAY;
      x_q      <= 9'd0;
      o_q      <= 9'd0;
      turn_q   <= FIRST_PLAYER;
      cnt_q    <= 4'd0;
      result_q <= 2'b00;
      fault_q  <= 1'b0;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (move_valid) begin
            if (legal_d) begin
              if (turn_q) o_q <= o_q | cell_mask_d;
              else        x_q <= x_q | cell_mask_d;
              cnt_q    <= cnt_q + 4'd1;
              accept_q <= 1'b1;
              state_q  <= S_CHECK;
            end else begin
              reject_q <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (error) begin
            fault_q  <= 1'b1;
            result_q <= 2'b00;
            state_q  <= S_DONE;
          end else if (win_x) begin
            result_q <= 2'b01;
            state_q  <= S_DONE;
          end else if (win_o) begin
            result_q <= 2'b10;
            state_q  <= S_DONE;
          end else if (full) begin
            result_q <= 2'b11;
            state_q  <= S_DONE;
          end else begin
            turn_q  <= ~turn_q;
            state_q <= S_PLAY;
          end
        end
        S_DONE: begin
          if (move_valid) reject_q <= 1'b1;
        end
        default: state_q <= S_PLAY;
      endcase
    end
  end

  assign move_ready  = (state_q == S_PLAY);
  assign game_over   = (state_q == S_DONE);
  assign move_accept = accept_q;
  assign move_reject = reject_q;
  assign x_board     = x_q;
  assign o_board     = o_q;
  assign turn        = turn_q;
  assign move_count  = cnt_q;
  assign result      = result_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_tictactoe_game_ctrl.sv
// Directed bench for tictactoe_game_ctrl with a behavioural board checker in the loop.
module tb_tictactoe_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       new_game;
  logic       move_valid;
  logic [3:0] move_pos;
  logic       move_ready, move_accept, move_reject;
  logic [8:0] x_board, o_board;
  logic       win_x, win_o, full, error;
  logic       turn;
  logic [3:0] move_count;
  logic       game_over;
  logic [1:0] result;
  logic       fault;
  logic       err_force;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  tictactoe_game_ctrl #(.FIRST_PLAYER(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game),
    .move_valid(move_valid), .move_pos(move_pos),
    .move_ready(move_ready), .move_accept(move_accept), .move_reject(move_reject),
    .x_board(x_board), .o_board(o_board),
    .win_x(win_x), .win_o(win_o), .full(full), .error(error),
    .turn(turn), .move_count(move_count), .game_over(game_over),
    .result(result), .fault(fault)
  );

  function automatic logic has_line(input logic [8:0] b);
    return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
           (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
           (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  // Reference checker
  always_comb begin
    win_x = has_line(x_board);
    win_o = has_line(o_board);
    full  = &(x_board | o_board);
    error = err_force | (|(x_board & o_board));
  end

  task automatic do_move(input logic [3:0] pos, input logic exp_acc, input logic exp_done);
    move_valid = 1'b1;
    move_pos   = pos;
    @(posedge clk); #1;
    move_valid = 1'b0;
    tests_run++;
    if (move_accept !== exp_acc || move_reject !== !exp_acc) begin
      tests_failed++;
      $display("FAIL move_handshake pos=%0d: accept=%b reject=%b expected accept=%b reject=%b",
               pos, move_accept, move_reject, exp_acc, !exp_acc);
    end
    if (exp_acc) begin
      tests_run++;
      if (move_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL check_ready pos=%0d: got %b expected 0", pos, move_ready);
      end
      @(posedge clk); #1;
      tests_run++;
      if (game_over !== exp_done) begin
        tests_failed++;
        $display("FAIL game_over pos=%0d: got %b expected %b", pos, game_over, exp_done);
      end
    end
  endtask

  task automatic start_game();
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    tests_run++;
    if (x_board !== 9'd0 || o_board !== 9'd0 || move_count !== 4'd0 || turn !== 1'b0 ||
        result !== 2'b00 || game_over !== 1'b0 || fault !== 1'b0 || move_ready !== 1'b1 ||
        move_accept !== 1'b0 || move_reject !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: x=%b o=%b cnt=%0d turn=%b res=%b over=%b fault=%b rdy=%b acc=%b rej=%b expected all clear, rdy=1",
               tag, x_board, o_board, move_count, turn, result, game_over, fault,
               move_ready, move_accept, move_reject);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_idle("reset_state");
  endtask

  task automatic test_x_wins();
    start_game();
    do_move(4'd0, 1'b1, 1'b0);
    do_move(4'd3, 1'b1, 1'b0);
    do_move(4'd1, 1'b1, 1'b0);
    do_move(4'd4, 1'b1, 1'b0);
    do_move(4'd2, 1'b1, 1'b1);
    tests_run++;
    if (result !== 2'b01 || x_board !== 9'b000000111 || o_board !== 9'b000011000 ||
        move_count !== 4'd5 || turn !== 1'b0 || move_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL x_wins: res=%b x=%b o=%b cnt=%0d turn=%b rdy=%b expected 01 000000111 000011000 5 0 0",
               result, x_board, o_board, move_count, turn, move_ready);
    end
  endtask

  task automatic test_o_wins();
    start_game();
    do_move(4'd0, 1'b1, 1'b0);
    do_move(4'd4, 1'b1, 1'b0);
    do_move(4'd1, 1'b1, 1'b0);
    do_move(4'd2, 1'b1, 1'b0);
    do_move(4'd8, 1'b1, 1'b0);
    do_move(4'd6, 1'b1, 1'b1);
    tests_run++;
    if (result !== 2'b10 || o_board !== 9'b001010100 || move_count !== 4'd6 || turn !== 1'b1) begin
      tests_failed++;
      $display("FAIL o_wins: res=%b o=%b cnt=%0d turn=%b expected 10 001010100 6 1",
               result, o_board, move_count, turn);
    end
  endtask

  task automatic test_draw();
    logic [3:0] seq [9];
    seq = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};
    start_game();
    for (int i = 0; i < 9; i++) do_move(seq[i], 1'b1, (i == 8));
    tests_run++;
    if (result !== 2'b11 || move_count !== 4'd9 || x_board !== 9'b110001101 ||
        o_board !== 9'b001110010) begin
      tests_failed++;
      $display("FAIL draw: res=%b cnt=%0d x=%b o=%b expected 11 9 110001101 001110010",
               result, move_count, x_board, o_board);
    end
  endtask

  task automatic test_illegal();
    start_game();
    do_move(4'd4, 1'b1, 1'b0);
    do_move(4'd4, 1'b0, 1'b0);
    tests_run++;
    if (move_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ready_after_reject: got %b expected 1", move_ready);
    end
    do_move(4'd9, 1'b0, 1'b0);
    tests_run++;
    if (o_board !== 9'd0 || x_board !== 9'b000010000 || turn !== 1'b1 || move_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL illegal_state: x=%b o=%b turn=%b cnt=%0d expected 000010000 0 1 1",
               x_board, o_board, turn, move_count);
    end
    do_move(4'd0, 1'b1, 1'b0);
    tests_run++;
    if (o_board !== 9'b000000001 || turn !== 1'b0 || move_count !== 4'd2) begin
      tests_failed++;
      $display("FAIL after_illegal: o=%b turn=%b cnt=%0d expected 000000001 0 2",
               o_board, turn, move_count);
    end
  endtask

  task automatic test_back_to_back();
    start_game();
    move_valid = 1'b1;
    move_pos   = 4'd0;
    @(posedge clk); #1;
    move_pos = 4'd1;
    @(posedge clk); #1;
    tests_run++;
    if (move_accept !== 1'b0 || move_reject !== 1'b0 || move_ready !== 1'b1 || o_board !== 9'd0) begin
      tests_failed++;
      $display("FAIL valid_in_check: acc=%b rej=%b rdy=%b o=%b expected 0 0 1 000000000",
               move_accept, move_reject, move_ready, o_board);
    end
    @(posedge clk); #1;
    move_valid = 1'b0;
    tests_run++;
    if (move_accept !== 1'b1 || o_board !== 9'b000000010 || x_board !== 9'b000000001 ||
        move_count !== 4'd2) begin
      tests_failed++;
      $display("FAIL second_accept: acc=%b x=%b o=%b cnt=%0d expected 1 000000001 000000010 2",
               move_accept, x_board, o_board, move_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_done_restart();
    start_game();
    do_move(4'd0, 1'b1, 1'b0);
    do_move(4'd3, 1'b1, 1'b0);
    do_move(4'd1, 1'b1, 1'b0);
    do_move(4'd4, 1'b1, 1'b0);
    do_move(4'd2, 1'b1, 1'b1);
    do_move(4'd5, 1'b0, 1'b0);
    tests_run++;
    if (x_board !== 9'b000000111 || o_board !== 9'b000011000 || result !== 2'b01 ||
        game_over !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_hold: x=%b o=%b res=%b over=%b expected 000000111 000011000 01 1",
               x_board, o_board, result, game_over);
    end
    new_game   = 1'b1;
    move_valid = 1'b1;
    move_pos   = 4'd5;
    @(posedge clk); #1;
    new_game   = 1'b0;
    move_valid = 1'b0;
    check_idle("new_game_restart");
  endtask

  task automatic test_fault_reset();
    start_game();
    move_valid = 1'b1;
    move_pos   = 4'd0;
    @(posedge clk); #1;
    move_valid = 1'b0;
    err_force  = 1'b1;
    @(posedge clk); #1;
    err_force  = 1'b0;
    tests_run++;
    if (fault !== 1'b1 || result !== 2'b00 || game_over !== 1'b1 || turn !== 1'b0) begin
      tests_failed++;
      $display("FAIL fault: fault=%b res=%b over=%b turn=%b expected 1 00 1 0",
               fault, result, game_over, turn);
    end
    @(posedge clk); #1;
    tests_run++;
    if (fault !== 1'b1) begin
      tests_failed++;
      $display("FAIL fault_sticky: got %b expected 1", fault);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_idle("reset_after_fault");
    do_move(4'd4, 1'b1, 1'b0);
    tests_run++;
    if (x_board !== 9'b000010000) begin
      tests_failed++;
      $display("FAIL pre_reset_move: x=%b expected 000010000", x_board);
    end
    move_valid = 1'b1;
    move_pos   = 4'd0;
    @(posedge clk); #1;
    move_valid = 1'b0;
    rst_n      = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_idle("reset_mid_check");
  endtask

  initial begin
    rst_n      = 1'b0;
    new_game   = 1'b0;
    move_valid = 1'b0;
    move_pos   = 4'd0;
    err_force  = 1'b0;
    test_reset();
    test_x_wins();
    test_o_wins();
    test_draw();
    test_illegal();
    test_back_to_back();
    test_done_restart();
    test_fault_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tictactoe_game_ctrl.md
# tictactoe_game_ctrl

Sequential game controller that sits directly upstream of the combinational tic-tac-toe board checker. It accepts player moves over a valid/ready handshake and keeps the registered X and O board vectors that drive the checker. It alternates turns and rejects illegal moves. It consumes the checker's win/full/error flags to declare the game result.

## Interface

**Parameters**
- `FIRST_PLAYER`, default 0: side that moves first after reset or `new_game`. 0 = X, 1 = O.

**Ports**
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `new_game`  in  1  single-cycle request to clear the board and restart.
- `move_valid`  in  1  a move is presented on `move_pos`.
- `move_pos`  in  4  cell index 0..8; bit i of the boards is cell i (row-major).
- `move_ready`  out  1  controller can accept a move this cycle.
- `move_accept`  out  1  one-cycle pulse: move applied.
- `move_reject`  out  1  one-cycle pulse: move refused.
- `x_board`  out  9  registered X occupancy; drives the checker `x` input.
- `o_board`  out  9  registered O occupancy; drives the checker `o` input.
- `win_x`, `win_o`, `full`, `error`  in  1 each  flags returned by the checker.
- `turn`  out  1  side to move: 0 = X, 1 = O.
- `move_count`  out  4  number of accepted moves, 0..9.
- `game_over`  out  1  high in DONE.
- `result`  out  2  result code: 00 = none, 01 = X wins, 10 = O wins, 11 = draw.
- `fault`  out  1  sticky; the checker reported `error` during CHECK.

## Operation

**States**
- PLAY: `move_ready` = 1.
- CHECK: `move_ready` = 0; lasts exactly one cycle.
- DONE: `move_ready` = 0.
- `move_ready` is decoded from state only.

**PLAY, when `move_valid` is high**
- Illegal move: `move_pos` > 8, or the cell is set in `x_board | o_board`.
  - Pulse `move_reject`.
  - Boards, `turn` and `move_count` are unchanged; stay in PLAY.
- Legal move:
  - Set the cell in `x_board` (`turn` = 0) or `o_board` (`turn` = 1).
  - `move_count` += 1.
  - Pulse `move_accept`; go to CHECK.

**CHECK**
- Evaluate the checker flags, which now reflect the updated registered boards, with this priority:
  1. `error`: `fault` = 1, `result` = 00, go to DONE.
  2. `win_x`: `result` = 01, go to DONE.
  3. `win_o`: `result` = 10, go to DONE.
  4. `full`: `result` = 11, go to DONE.
  5. Otherwise: toggle `turn`, go to PLAY.
- `turn` does not toggle on any transition into DONE.

**DONE**
- Boards and `result` hold.
- `move_valid` high pulses `move_reject` each cycle it is high.

**`new_game`**
- Accepted in any state; takes priority over `move_valid` in the same cycle. That move is dropped with neither accept nor reject.
- Next cycle: boards = 0, `turn` = `FIRST_PLAYER`, `move_count` = 0, `result` = 00, `game_over` = 0, `fault` = 0, state = PLAY.

**Reset**
- `rst_n` low at an edge gives the same values as `new_game`.
- `move_accept` = `move_reject` = 0.
- Applies from any state, including mid-CHECK.

## Timing

- The handshake is sampled at rising edge N when `move_valid` & `move_ready`.
- Legal move:
  - Board update, `move_accept` and the CHECK state all appear after edge N.
  - After edge N+1 the controller is in PLAY (`turn` toggled) or DONE (`game_over`, `result` valid).
- Throughput: at most one accepted move per 2 cycles. `move_valid` held high during CHECK is ignored there and considered again in PLAY.
- Reject: the pulse appears after edge N; stays in PLAY, so `move_ready` remains high.
- All outputs are registered or state-decoded. There is no combinational path from `move_*` inputs to outputs, so the board → checker → flags loop has no combinational cycle.

## Test plan

- **X wins:** after reset, moves 0,3,1,4,2.
  - 5 accepts.
  - One cycle after the last accept: `game_over` = 1, `result` = 01, `x_board` = 9'b000000111, `o_board` = 9'b000011000, `move_count` = 5, `turn` = 0.
- **O wins:** moves 0,4,1,2,8,6 → `result` = 10, `o_board` = 9'b001010100, `move_count` = 6.
- **Draw:** moves 0,1,2,4,3,5,7,6,8.
  - No DONE before the 9th move.
  - Then `result` = 11, `move_count` = 9, `x_board` = 9'b110001101.
- **Illegal moves:** move 4 (X), then O attempts 4, then O attempts 9.
  - Two `move_reject` pulses.
  - `o_board` = 0, `turn` = 1, `move_count` = 1.
  - A following O move to 0 is accepted.
- **DONE and restart:**
  - After an X win, `move_valid` to 5 → `move_reject`, boards unchanged.
  - `new_game` with simultaneous `move_valid` → next cycle boards = 0, `move_count` = 0, `result` = 00, PLAY, no accept/reject.
- **Fault and reset:**
  - Force `error` = 1 during CHECK → DONE, `fault` = 1, `result` = 00.
  - `rst_n` = 0 for one edge while in CHECK → all outputs at reset values, `move_ready` = 1.
